// File: rtl/sort_arb_ctrl.sv
// sort_arb_ctrl: two-requester arbiter and sequencer for a shared
// sort-and-compute unit. The granted requester streams four nibbles and a
// mode. The block sorts the nibbles and returns a mode-selected signed result
// tagged with the requester id.
// Build option: define SORT_ARB_FIXED_PRIO_EN for fixed priority (req0 always
// wins). Leave it undefined for round-robin arbitration.
module sort_arb_ctrl #(
  parameter int unsigned LOAD_TIMEOUT = 32'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [1:0] in_valid,
  input  logic [7:0] in_number,
  input  logic [3:0] in_mode,
  output logic       out_valid,
  output logic [5:0] out_result,
  output logic       out_id,
  output logic       out_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CAL  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  // The idle count that aborts the transaction if one more empty edge occurs.
  localparam logic [7:0] IDLE_LAST = 8'(LOAD_TIMEOUT - 32'd1);

  typedef logic [3:0][3:0] nib4_t;

  // Five compare-exchange stages give an ascending order s[0] <= ... <= s[3].
  function automatic nib4_t sort4(input nib4_t v);
    nib4_t      s;
    logic [3:0] t;
    s = v;
    if (s[0] > s[1]) begin t = s[0]; s[0] = s[1]; s[1] = t; end else begin end
    if (s[2] > s[3]) begin t = s[2]; s[2] = s[3]; s[3] = t; end else begin end
    if (s[0] > s[2]) begin t = s[0]; s[0] = s[2]; s[2] = t; end else begin end
    if (s[1] > s[3]) begin t = s[1]; s[1] = s[3]; s[3] = t; end else begin end
    if (s[1] > s[2]) begin t = s[1]; s[1] = s[2]; s[2] = t; end else begin end
    return s;
  endfunction

  // The result range is -15..30. Computing modulo 64 on zero-extended
  // operands therefore gives the same 6-bit two's-complement value as the
  // wider arithmetic truncated to 6 bits.
  function automatic logic [5:0] calc(input logic [1:0] mode, input nib4_t s);
    logic [5:0] r;
    case (mode)
      2'd0:    r = {2'b00, s[0]} + {2'b00, s[1]};
      2'd1:    r = {2'b00, s[1]} - {2'b00, s[0]};
      2'd2:    r = {2'b00, s[3]} - {2'b00, s[2]};
      2'd3:    r = {2'b00, s[0]} - {2'b00, s[3]};
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  logic [1:0] state_q, state_d;
  logic       id_q, id_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] idle_q, idle_d;
  nib4_t      nib_q, nib_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic [5:0] result_q, result_d;
  logic       oid_q, oid_d;
  logic       err_q, err_d;

  logic       winner_s;
  logic       accept_s;
  logic [3:0] num_s;
  logic [1:0] mode_s;

`ifdef SORT_ARB_FIXED_PRIO_EN
  // Fixed priority: req0 beats req1 whenever both are asking.
  always_comb begin
    if (req[0]) begin
      winner_s = 1'b0;
    end else begin
      winner_s = 1'b1;
    end
  end
`else
  logic last_q;

  // Round-robin: on a tie, the requester not served last wins.
  always_comb begin
    if (req == 2'b11) begin
      winner_s = ~last_q;
    end else if (req[0]) begin
      winner_s = 1'b0;
    end else begin
      winner_s = 1'b1;
    end
  end

  // Remember who was granted last. The reset value of 1 hands the first tie to req0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if ((state_q == ST_IDLE) && (req != 2'b00)) begin
      last_q <= winner_s;
    end
  end
`endif

  // Pick only the granted requester's lanes. The other requester's lanes are ignored.
  always_comb begin
    if (id_q) begin
      num_s  = in_number[7:4];
      mode_s = in_mode[3:2];
    end else begin
      num_s  = in_number[3:0];
      mode_s = in_mode[1:0];
    end
    accept_s = (state_q == ST_LOAD) && in_valid[id_q];
  end

  // Next-state and output-register logic for the IDLE/LOAD/CAL/OUT sequence.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    nib_d    = nib_q;
    mode_d   = mode_q;
    gnt_d    = gnt_q;
    valid_d  = 1'b0;
    result_d = 6'd0;
    oid_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          id_d    = winner_s;
          gnt_d   = winner_s ? 2'b10 : 2'b01;
          cnt_d   = 2'd0;
          idle_d  = 8'd0;
          state_d = ST_LOAD;
        end else begin
          gnt_d = 2'b00;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          nib_d[cnt_q] = num_s;
          idle_d       = 8'd0;
          if (cnt_q == 2'd0) begin
            mode_d = mode_s;
          end else begin
            mode_d = mode_q;
          end
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            gnt_d   = 2'b00;
            state_d = ST_CAL;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (idle_q == IDLE_LAST) begin
          // Abort: report an error result straight away.
          gnt_d   = 2'b00;
          cnt_d   = 2'd0;
          idle_d  = 8'd0;
          valid_d = 1'b1;
          err_d   = 1'b1;
          oid_d   = id_q;
          state_d = ST_OUT;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      ST_CAL: begin
        valid_d  = 1'b1;
        result_d = calc(mode_q, sort4(nib_q));
        oid_d    = id_q;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        cnt_d   = 2'd0;
        idle_d  = 8'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs. Reset discards any partially loaded data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      id_q     <= 1'b0;
      cnt_q    <= 2'd0;
      idle_q   <= 8'd0;
      nib_q    <= '0;
      mode_q   <= 2'd0;
      gnt_q    <= 2'b00;
      valid_q  <= 1'b0;
      result_q <= 6'd0;
      oid_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      nib_q    <= nib_d;
      mode_q   <= mode_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      oid_q    <= oid_d;
      err_q    <= err_d;
    end
  end

  assign gnt        = gnt_q;
  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_id     = oid_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_sort_arb_ctrl.sv
// Self-checking bench for sort_arb_ctrl: table vectors, random transactions
// against a reference model, and hand-written arbitration, isolation,
// timeout and reset sequences.
module tb_sort_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] gnt;
  logic [1:0] in_valid = 2'b00;
  logic [7:0] in_number = 8'd0;
  logic [3:0] in_mode = 4'd0;
  logic       out_valid;
  logic [5:0] out_result;
  logic       out_id;
  logic       out_err;

  int n_total = 0;
  int n_pass  = 0;

  sort_arb_ctrl #(.LOAD_TIMEOUT(32'd15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .in_valid(in_valid), .in_number(in_number), .in_mode(in_mode),
    .out_valid(out_valid), .out_result(out_result),
    .out_id(out_id), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [1:0]  mode;
    logic [15:0] nibs;   // n0 in [15:12] ... n3 in [3:0]
    logic [5:0]  exp;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sort the four values and apply the mode rule in plain integers.
  function automatic logic [5:0] model(input logic [1:0] mode, input logic [15:0] nibs);
    int v[4];
    int t;
    int r;
    for (int i = 0; i < 4; i++) v[i] = int'(nibs[15 - 4*i -: 4]);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    case (mode)
      2'd0: r = v[0] + v[1];
      2'd1: r = v[1] - v[0];
      2'd2: r = v[3] - v[2];
      default: r = v[0] - v[3];
    endcase
    return 6'(r);
  endfunction

  task automatic noise(input int other, input bit busy15);
    in_valid[other]          = busy15 ? 1'b1 : 1'($urandom_range(0, 1));
    in_number[4*other +: 4]  = busy15 ? 4'd15 : 4'($urandom_range(0, 15));
    in_mode[2*other +: 2]    = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_grant(input int id);
    int waited = 0;
    req[id] = 1'b1;
    while (gnt !== (2'b01 << id) && waited < 10) begin step(); waited++; end
    chk("gnt_rise", int'(gnt), int'(2'b01 << id));
    req[id] = 1'b0;   // dropping req during LOAD must not matter
  endtask

  // One full transaction with optional input gaps and noise on the other lane.
  task automatic do_txn(input int id, input logic [1:0] mode, input logic [15:0] nibs,
                        input logic [5:0] exp, input int maxgap, input bit busy15);
    int other = 1 - id;
    int gaps;
    wait_grant(id);
    for (int k = 0; k < 4; k++) begin
      gaps = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid[id] = 1'b0;
        noise(other, busy15);
        step();
        chk("gnt_gap", int'(gnt), int'(2'b01 << id));
      end
      in_valid[id]            = 1'b1;
      in_number[4*id +: 4]    = nibs[15 - 4*k -: 4];
      in_mode[2*id +: 2]      = (k == 0) ? mode : 2'($urandom_range(0, 3));
      noise(other, busy15);
      step();
      if (k < 3) chk("gnt_load", int'(gnt), int'(2'b01 << id));
    end
    in_valid = 2'b00;
    chk("cal_quiet", int'({gnt, out_valid}), 0);
    step();
    chk("out_valid", int'(out_valid), 1);
    chk("out_result", int'(out_result), int'(exp));
    chk("out_id", int'(out_id), id);
    chk("out_err", int'(out_err), 0);
    step();
    chk("out_clear", int'({out_valid, out_result, out_id, out_err}), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 2'b00; in_valid = 2'b00;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  vec_t vecs[6];
  int   ids[3];
  int   res[3];
  int   cyc[3];
  int   seen;
  int   cycle;
  logic [15:0] rn;
  logic [1:0]  rm;
  int          rid;

  initial begin
    vecs[0] = '{1'b0, 2'd0, {4'd3, 4'd9, 4'd1, 4'd7},    6'd4};
    vecs[1] = '{1'b1, 2'd3, {4'd3, 4'd9, 4'd1, 4'd7},    6'b111000};
    vecs[2] = '{1'b1, 2'd0, {4'd15, 4'd15, 4'd15, 4'd15}, 6'd30};
    vecs[3] = '{1'b1, 2'd1, {4'd2, 4'd2, 4'd15, 4'd0},   6'd2};
    vecs[4] = '{1'b1, 2'd2, {4'd15, 4'd15, 4'd0, 4'd0},  6'd0};
    vecs[5] = '{1'b0, 2'd3, {4'd0, 4'd15, 4'd0, 4'd0},   6'b110001};

    // Reset state
    #2;
    chk("rst_outputs", int'({gnt, out_valid, out_result, out_id, out_err}), 0);
    do_reset();
    chk("post_rst_outputs", int'({gnt, out_valid, out_result, out_id, out_err}), 0);

    // Table vectors
    foreach (vecs[i])
      do_txn(int'(vecs[i].id), vecs[i].mode, vecs[i].nibs, vecs[i].exp, 0, 1'b0);

    // Isolation: requester 1 floods 15s while requester 0 is served
    do_txn(0, 2'd1, {4'd4, 4'd1, 4'd8, 4'd2}, 6'd1, 0, 1'b1);

    // Random transactions against the reference model
    for (int t = 0; t < 24; t++) begin
      rid = $urandom_range(0, 1);
      rm  = 2'($urandom_range(0, 3));
      rn  = 16'($urandom);
      do_txn(rid, rm, rn, model(rm, rn), 3, 1'b0);
    end

    // Timeout: two nibbles then silence, requester 1 still driving valid
    wait_grant(0);
    for (int k = 0; k < 2; k++) begin
      in_valid[0] = 1'b1; in_number[3:0] = 4'd5;
      noise(1, 1'b1);
      step();
    end
    in_valid[0] = 1'b0;
    seen = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i < 15 && (out_valid !== 1'b0 || gnt !== 2'b01)) seen++;
    end
    chk("timeout_early", seen, 0);
    chk("timeout_valid", int'(out_valid), 1);
    chk("timeout_err", int'(out_err), 1);
    chk("timeout_result", int'(out_result), 0);
    chk("timeout_id", int'(out_id), 0);
    chk("timeout_gnt", int'(gnt), 0);
    in_valid = 2'b00;
    step();
    chk("timeout_clear", int'({out_valid, out_err}), 0);

    // Reset mid-transaction, then a clean transaction
    wait_grant(0);
    for (int k = 0; k < 2; k++) begin
      in_valid[0] = 1'b1; in_number[3:0] = 4'd15; in_mode[1:0] = 2'd2;
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", int'({gnt, out_valid, out_result, out_id, out_err}), 0);
    in_valid = 2'b00;
    step();
    rst_n = 1'b1;
    step();
    do_txn(0, 2'd0, {4'd3, 4'd9, 4'd1, 4'd7}, 6'd4, 0, 1'b0);

    // Arbitration with both requests held from reset
    do_reset();
    req = 2'b11; in_valid = 2'b11;
    in_number = {4'd6, 4'd5}; in_mode = 4'd0;
    seen = 0; cycle = 0;
    while (seen < 3 && cycle < 60) begin
      step(); cycle++;
      if (out_valid === 1'b1) begin
        ids[seen] = int'(out_id); res[seen] = int'(out_result); cyc[seen] = cycle;
        seen++;
      end
    end
    req = 2'b00; in_valid = 2'b00;
    chk("rr_count", seen, 3);
    if (seen == 3) begin
`ifdef SORT_ARB_FIXED_PRIO_EN
      chk("arb_id0", ids[0], 0); chk("arb_id1", ids[1], 0); chk("arb_id2", ids[2], 0);
`else
      chk("arb_id0", ids[0], 0); chk("arb_id1", ids[1], 1); chk("arb_id2", ids[2], 0);
`endif
      for (int i = 0; i < 3; i++) chk("arb_result", res[i], (ids[i] == 0) ? 10 : 12);
      chk("arb_interval1", cyc[1] - cyc[0], 7);
      chk("arb_interval2", cyc[2] - cyc[1], 7);
    end
    step(); step();
    chk("final_idle", int'({gnt, out_valid}), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sort_arb_ctrl.md
Name: sort_arb_ctrl

Overview:
- Arbitrates two requesters for one shared sort-and-compute unit and sequences its operation.
- Each requester raises a request, receives a grant, then streams four 4-bit numbers plus a 2-bit mode.
- The block sorts the four numbers, computes a mode-selected signed result, and returns it tagged with the requester id.
- Sits between the requester FSMs and the result consumer; the sort network and arithmetic are internal.

Parameters:
- LOAD_TIMEOUT, 15: consecutive LOAD cycles without an accepted nibble before the transaction is aborted. Legal range 2..255; counter is 8 bits.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  2  req[i]=1: requester i wants the unit.
- gnt  out  2  one-hot; gnt[i] high for every cycle the block is in LOAD serving i.
- in_valid  in  2  in_valid[i]: requester i drives a valid nibble.
- in_number  in  8  requester i data on bits [4i+3:4i], unsigned.
- in_mode  in  4  requester i mode on bits [2i+1:2i].
- out_valid  out  1  one-cycle result strobe.
- out_result  out  6  signed two's-complement result.
- out_id  out  1  id of the requester being answered.
- out_err  out  1  high with out_valid when the transaction timed out.

Behaviour:
- Reset: state IDLE, all outputs 0, rr pointer favours req0, nibble count 0, idle counter 0. Reset mid-transaction discards all captured data.
- States: IDLE, LOAD, CAL, OUT; all outputs are registered.
- IDLE, no req bits set: stay in IDLE.
- IDLE, any req bit set: pick the winner, latch it as id, go to LOAD. gnt[id] goes high in the first LOAD cycle.
- Round-robin winner selection:
  - If both req bits are set, the requester not served last wins.
  - After reset, req0 wins a tie.
  - The pointer updates when the grant is issued.
- LOAD:
  - A nibble is accepted on an edge where in_valid[id]=1. Nibbles are stored in arrival order n0..n3.
  - in_mode[id] is captured with n0 only.
  - in_valid, in_number and in_mode of the non-granted requester are ignored.
  - Dropping req[id] during LOAD has no effect.
  - On the edge accepting n3: go to CAL and clear gnt.
- Idle counter (LOAD only):
  - Increments on each LOAD edge with no accepted nibble; clears on an accepted nibble.
  - On the edge where it would reach LOAD_TIMEOUT: abort, go directly to OUT with out_err=1, out_result=0.
- CAL (one cycle):
  - Sort n0..n3 ascending, unsigned, to s0<=s1<=s2<=s3.
  - Compute and register the result:
    - mode 0: s0+s1
    - mode 1: s1-s0
    - mode 2: s3-s2
    - mode 3: s0-s3
  - Operands are zero-extended to 7 bits. The result range is -15..30, so truncation to 6 bits signed is lossless.
- OUT (one cycle):
  - out_valid=1, with out_result, out_id, out_err driven.
  - Next state is IDLE.
  - All four outputs return to 0 in every non-OUT cycle.
- Latency: 4th nibble accepted at edge k → CAL after edge k → out_valid high in the cycle after edge k+1.
- Back-to-back: a req held during OUT is evaluated in the IDLE cycle that follows. Minimum issue interval is 7 cycles (IDLE + 4 LOAD + CAL + OUT).

Optional Feature:
- Macro SORT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; req0 always wins over req1, and the rr pointer is removed.
- Undefined: round-robin as specified above.

Test Plan:
- Single request, req0 with mode 0, nibbles 3, 9, 1, 7 → gnt=01 for 4 LOAD cycles; out_valid with out_result=4, out_id=0, out_err=0, two cycles after the last nibble.
- Arithmetic corners on req1:
  - Mode 3 with 3, 9, 1, 7 → -8 (6'b111000).
  - Mode 0 with 15, 15, 15, 15 → 30.
  - Mode 1 with 2, 2, 15, 0 → 2.
  - Mode 2 with 15, 15, 0, 0 → 0.
- Round-robin:
  - req=11 held continuously → grants go req0, req1, req0; out_id sequence 0, 1, 0.
  - With SORT_ARB_FIXED_PRIO_EN defined → 0, 0, 0.
- Isolation: while req0 is granted, requester 1 drives in_valid[1]=1 with 15 every cycle → result uses only requester 0 data; gnt[1] stays 0.
- Timeout: grant req0, send 2 nibbles, then none → after 15 idle LOAD cycles out_valid=1, out_err=1, out_result=0, out_id=0, then back to IDLE.
- Reset: assert rst_n=0 after 2 nibbles → outputs 0 immediately. A new request after release completes normally and ignores the earlier nibbles.
